// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: debug-side run/step controller.
// Drives the pipeline step enable and streams PC + cycle count to the UART.
module debug_step_ctrl #(
  parameter int SIZE_ADDR_PC = 32,
  parameter int SIZE_CYCLES  = 32,
  parameter int SIZE_BYTE    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  input  logic [SIZE_BYTE-1:0]    i_cmd,
  output logic                    o_cmd_ready,
  input  logic [SIZE_ADDR_PC-1:0] i_pc,
  input  logic                    i_halt,
  output logic                    o_step,
  output logic [SIZE_BYTE-1:0]    o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_halted
);

  localparam int BUF_W  = SIZE_ADDR_PC + SIZE_CYCLES;
  localparam int NBYTES = BUF_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] STEP   = 3'd2;
  localparam logic [2:0] REPORT = 3'd3;
  localparam logic [2:0] SEND   = 3'd4;

  localparam logic [SIZE_BYTE-1:0] CMD_C = SIZE_BYTE'(8'h63);
  localparam logic [SIZE_BYTE-1:0] CMD_S = SIZE_BYTE'(8'h73);
  localparam logic [SIZE_BYTE-1:0] CMD_P = SIZE_BYTE'(8'h70);

  logic [2:0]             state;
  logic                   step_q;
  logic                   halted_q;
  logic [SIZE_CYCLES-1:0] cycles;
  logic [BUF_W-1:0]       tx_buf;
  logic [IDX_W-1:0]       tx_idx;

  logic cmd_fire;
  logic tx_fire;
  logic last_byte;
  logic is_c;
  logic is_s;
  logic is_p;
  logic go_run;
  logic go_step;
  logic go_rep;

  assign o_cmd_ready = (state == IDLE);
  assign o_tx_valid  = (state == SEND);
  assign o_step      = step_q;
  assign o_halted    = halted_q;
  assign o_tx_data   = SIZE_BYTE'(tx_buf[BUF_W-1 -: 8]);

  assign cmd_fire  = i_cmd_valid & o_cmd_ready;
  assign tx_fire   = o_tx_valid & i_tx_ready;
  assign last_byte = (tx_idx == IDX_W'(NBYTES - 1));

  assign is_c = (i_cmd == CMD_C);
  assign is_s = (i_cmd == CMD_S);
  assign is_p = (i_cmd == CMD_P);

  // once halted, run/step only re-issue the report
  assign go_run  = is_c & ~halted_q;
  assign go_step = is_s & ~halted_q;
  assign go_rep  = is_p | ((is_c | is_s) & halted_q);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      step_q   <= 1'b0;
      halted_q <= 1'b0;
      cycles   <= '0;
      tx_buf   <= '0;
      tx_idx   <= '0;
    end else begin
      halted_q <= halted_q | i_halt;
      if (step_q) begin
        cycles <= cycles + SIZE_CYCLES'(1);
      end
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            unique case (1'b1)
              go_run: begin
                state  <= RUN;
                step_q <= 1'b1;
              end
              go_step: begin
                state  <= STEP;
                step_q <= 1'b1;
              end
              go_rep: begin
                state <= REPORT;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
        RUN: begin
          if (i_halt) begin
            step_q <= 1'b0;
            state  <= REPORT;
          end
        end
        STEP: begin
          step_q <= 1'b0;
          state  <= REPORT;
        end
        REPORT: begin
          tx_buf <= {i_pc, cycles};
          tx_idx <= '0;
          state  <= SEND;
        end
        SEND: begin
          if (tx_fire) begin
            // empties to zero after the last byte
            tx_buf <= {tx_buf[BUF_W-9:0], 8'h00};
            tx_idx <= tx_idx + IDX_W'(1);
            if (last_byte) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          step_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// tb_debug_step_ctrl: directed + random bench for debug_step_ctrl.
// Transaction-level reference with a per-cycle compare.
module tb_debug_step_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [7:0]  i_cmd = 8'h00;
  logic        o_cmd_ready;
  logic [31:0] i_pc = 32'h0;
  logic        i_halt = 1'b0;
  logic        o_step;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_halted;

  debug_step_ctrl #(
    .SIZE_ADDR_PC(32),
    .SIZE_CYCLES (32),
    .SIZE_BYTE   (8)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd      (i_cmd),
    .o_cmd_ready(o_cmd_ready),
    .i_pc       (i_pc),
    .i_halt     (i_halt),
    .o_step     (o_step),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_halted   (o_halted)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference: pending work flags plus a queue of bytes still to send
  logic        m_run = 1'b0;
  logic        m_one = 1'b0;
  logic        m_rep = 1'b0;
  logic        m_halted = 1'b0;
  logic        m_acc = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic [7:0]  m_txq[$];

  logic [7:0]  rxq[$];
  int          dut_steps = 0;

  int   rdy_mode = 0;
  int   stall_left = 0;
  logic halt_rand = 1'b0;
  logic halt_req = 1'b0;
  logic pc_rand = 1'b0;

  function automatic logic m_idle();
    return !(m_run || m_one || m_rep || (m_txq.size() != 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, expected completion", name);
  endtask

  task automatic chk_rx(input string name, input logic [63:0] e);
    chk({name, "_len"}, 32'(rxq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk(name, (k < rxq.size()) ? 32'(rxq[k]) : 32'hFFFF_FFFF,
          32'(e[63-8*k -: 8]));
    end
  endtask

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_run = 1'b0;
      m_one = 1'b0;
      m_rep = 1'b0;
      m_txq.delete();
      m_halted = 1'b0;
      m_cnt = 32'h0;
      m_pc = 32'h0;
      m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (m_run || m_one) begin
        m_cnt += 1;
        m_pc += 4;
      end
      if (m_txq.size() != 0) begin
        if (i_tx_ready) void'(m_txq.pop_front());
      end else if (m_rep) begin
        for (int k = 3; k >= 0; k--)
          m_txq.push_back(8'(i_pc >> (8 * k)));
        for (int k = 3; k >= 0; k--)
          m_txq.push_back(8'(m_cnt >> (8 * k)));
        m_rep = 1'b0;
      end else if (m_one) begin
        m_one = 1'b0;
        m_rep = 1'b1;
      end else if (m_run) begin
        if (i_halt) begin
          m_run = 1'b0;
          m_rep = 1'b1;
        end
      end else if (i_cmd_valid) begin
        m_acc = 1'b1;
        if (i_cmd == 8'h70 ||
            (m_halted && (i_cmd == 8'h63 || i_cmd == 8'h73)))
          m_rep = 1'b1;
        else if (i_cmd == 8'h63)
          m_run = 1'b1;
        else if (i_cmd == 8'h73)
          m_one = 1'b1;
      end
      m_halted = m_halted | i_halt;
    end
  end

  always @(negedge i_clk) begin
    chk("cmd_ready", 32'(o_cmd_ready), 32'(m_idle()));
    chk("step", 32'(o_step), 32'(m_run || m_one));
    chk("halted", 32'(o_halted), 32'(m_halted));
    chk("tx_valid", 32'(o_tx_valid), 32'(m_txq.size() != 0));
    chk("tx_data", 32'(o_tx_data),
        (m_txq.size() != 0) ? 32'(m_txq[0]) : 32'h0);
    if (o_tx_valid && i_tx_ready) rxq.push_back(o_tx_data);
    if (o_step) dut_steps++;
  end

  always @(posedge i_clk) begin
    #2;
    case (rdy_mode)
      0: i_tx_ready = 1'b1;
      1: i_tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (rxq.size() == 3 && stall_left > 0) begin
          i_tx_ready = 1'b0;
          stall_left--;
        end else if (rxq.size() < 3) begin
          i_tx_ready = 1'b1;
        end else begin
          i_tx_ready = 1'($urandom_range(0, 1));
        end
      end
    endcase
    i_halt = halt_rand ? ($urandom_range(0, 7) == 0) : halt_req;
    i_pc = pc_rand ? $urandom : m_pc;
  end

  task automatic send_cmd(input logic [7:0] c, input int budget);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    for (int t = 0; t < budget; t++) begin
      @(posedge i_clk);
      #1;
      if (m_acc) begin
        i_cmd_valid = 1'b0;
        return;
      end
    end
    i_cmd_valid = 1'b0;
    timeout_fail("cmd_accept");
  endtask

  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(posedge i_clk);
      #1;
      if (m_idle()) return;
    end
    timeout_fail("wait_idle");
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
  endtask

  task automatic clear_obs();
    rxq.delete();
    dut_steps = 0;
  endtask

  initial begin
    @(posedge i_clk);
    #2;
    chk("rst_step", 32'(o_step), 32'd0);
    chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;

    clear_obs();
    send_cmd(8'h73, 20);
    wait_idle(50);
    chk_rx("s1_bytes", 64'h00000004_00000001);
    chk("s1_steps", 32'(dut_steps), 32'd1);
    chk("s1_ready", 32'(o_cmd_ready), 32'd1);

    clear_obs();
    send_cmd(8'h63, 20);
    repeat (8) @(posedge i_clk);
    #1;
    halt_req = 1'b1;
    wait_idle(50);
    halt_req = 1'b0;
    chk_rx("c_bytes", 64'h00000028_0000000A);
    chk("c_steps", 32'(dut_steps), 32'd9);
    chk("c_halted", 32'(o_halted), 32'd1);

    clear_obs();
    send_cmd(8'h73, 20);
    wait_idle(50);
    chk_rx("hs_bytes", 64'h00000028_0000000A);
    chk("hs_steps", 32'(dut_steps), 32'd0);

    clear_obs();
    rdy_mode = 2;
    stall_left = 5;
    send_cmd(8'h70, 20);
    wait_idle(200);
    rdy_mode = 0;
    chk_rx("stall_bytes", 64'h00000028_0000000A);

    clear_obs();
    send_cmd(8'h41, 20);
    chk("drop_ready", 32'(o_cmd_ready), 32'd1);
    send_cmd(8'h70, 20);
    wait_idle(50);
    chk_rx("drop_bytes", 64'h00000028_0000000A);
    chk("drop_steps", 32'(dut_steps), 32'd0);

    do_reset();
    send_cmd(8'h63, 20);
    repeat (3) @(posedge i_clk);
    #1;
    chk("run_step", 32'(o_step), 32'd1);
    i_reset = 1'b0;
    #1;
    chk("mid_rst_step", 32'(o_step), 32'd0);
    chk("mid_rst_valid", 32'(o_tx_valid), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    clear_obs();
    send_cmd(8'h70, 20);
    wait_idle(50);
    chk_rx("post_rst_bytes", 64'h0);
    chk("post_rst_halted", 32'(o_halted), 32'd0);

    rdy_mode = 1;
    halt_rand = 1'b1;
    pc_rand = 1'b1;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0: send_cmd(8'h63, 400);
          1: send_cmd(8'h73, 400);
          2: send_cmd(8'h70, 400);
          default: send_cmd(8'($urandom), 400);
        endcase
        if ($urandom_range(0, 1) == 1) wait_idle(400);
      end
    end
    halt_rand = 1'b0;
    pc_rand = 1'b0;
    wait_idle(1000);
    repeat (2) @(posedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
